bsg_link_token_credit_tx: RTL and testbench



---
 rtl/bsg_link_token_credit_tx.sv | 191 +++++++++++++++++++
 tb/tb_bsg_link_token_credit_tx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bsg_link_token_credit_tx.sv
// ---------------------------------------------------------------------------
// bsg_link_token_credit_tx
//
// Transmit-side credit manager for the DDR source-synchronous link. The
// remote receiver frees FIFO slots and returns one token rising edge for every
// 2^lg_credit_to_token_decimation_p of them. This block synchronizes that
// token into clk_i and turns each rising edge into credits. It gates the
// upstream valid/ready handshake so that the remote FIFO can never overflow.
//
// Optional feature (compile-time macro BSG_LINK_CREDIT_STALL_WATCHDOG_EN):
//   When the macro is defined, a stall watchdog counts cycles in which upstream
//   has a word ready to send but no credit is available. stall_o is raised
//   once the count reaches watchdog_cycles_p. When the macro is undefined,
//   no counter is built and stall_o is tied to 0.
//
// Ports:
//   clk_i          io clock
//   reset_i        asynchronous, active-high reset
//   link_enable_i  link enabled; when 0, nothing is sent and credit sits at max
//   valid_i        upstream word valid
//   data_i         upstream word
//   ready_o        upstream may send (valid/ready handshake, no valid_i path)
//   valid_o        registered word valid to the serializer
//   data_o         registered word to the serializer
//   token_i        raw token from the remote receiver (asynchronous)
//   credit_o       current credit count, 0 .. 2^lg_fifo_depth_p
//   overflow_o     sticky: a token would have pushed credit above maximum
//   stall_o        watchdog flag (0 when the watchdog is compiled out)
// ---------------------------------------------------------------------------
module bsg_link_token_credit_tx #(
  parameter int width_p                         = 32,
  parameter int lg_fifo_depth_p                 = 6,
  parameter int lg_credit_to_token_decimation_p = 3,
  parameter int watchdog_cycles_p               = 1024
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     link_enable_i,
  input  logic                     valid_i,
  input  logic [width_p-1:0]       data_i,
  output logic                     ready_o,
  output logic                     valid_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     token_i,
  output logic [lg_fifo_depth_p:0] credit_o,
  output logic                     overflow_o,
  output logic                     stall_o
);

  localparam int credit_w_lp = lg_fifo_depth_p + 1;
  // One extra bit so that credit + token increment can exceed MAX and be seen.
  localparam int calc_w_lp   = lg_fifo_depth_p + 2;

  localparam logic [calc_w_lp-1:0]   max_calc_lp   = calc_w_lp'(2 ** lg_fifo_depth_p);
  localparam logic [credit_w_lp-1:0] max_credit_lp = credit_w_lp'(2 ** lg_fifo_depth_p);
  localparam logic [calc_w_lp-1:0]   token_inc_lp  = calc_w_lp'(2 ** lg_credit_to_token_decimation_p);

  // -------------------------------------------------------------------------
  // Token synchronizer. s1/s2 form the two-flop synchronizer. s3 holds the
  // previous synchronized value for rising-edge detection. The chain runs even
  // while the link is disabled. s3 therefore tracks the current token level,
  // and re-enabling the link cannot produce a false edge.
  // -------------------------------------------------------------------------
  logic token_s1_q, token_s2_q, token_s3_q;
  logic token_edge;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      token_s1_q <= 1'b0;
      token_s2_q <= 1'b0;
      token_s3_q <= 1'b0;
    end else begin
      token_s1_q <= token_i;
      token_s2_q <= token_s1_q;
      token_s3_q <= token_s2_q;
    end
  end

  assign token_edge = token_s2_q & ~token_s3_q;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic [credit_w_lp-1:0] credit_q, credit_d;
  logic                   overflow_q, overflow_d;
  logic                   send;

  assign ready_o = link_enable_i & (credit_q != '0);
  assign send    = valid_i & ready_o;

  // -------------------------------------------------------------------------
  // Credit arithmetic. A send and a token edge in the same cycle yield the
  // net result. Underflow is impossible because send requires credit != 0.
  // -------------------------------------------------------------------------
  logic [calc_w_lp-1:0] credit_next_calc;

  always_comb begin
    credit_d         = credit_q;
    overflow_d       = overflow_q;
    credit_next_calc = {1'b0, credit_q}
                     - calc_w_lp'(send)
                     + (token_edge ? token_inc_lp : '0);

    if (!link_enable_i) begin
      // Disabled link: tokens are ignored and the credit pool is refilled.
      credit_d = max_credit_lp;
    end else if (credit_next_calc > max_calc_lp) begin
      credit_d   = max_credit_lp;
      overflow_d = 1'b1;
    end else begin
      credit_d = credit_next_calc[credit_w_lp-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      credit_q   <= max_credit_lp;
      overflow_q <= 1'b0;
    end else begin
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
    end
  end

  assign credit_o   = credit_q;
  assign overflow_o = overflow_q;

  // -------------------------------------------------------------------------
  // Output register. Latency is fixed at one cycle. There is no downstream
  // backpressure, because the credits already guarantee room at the far end.
  // -------------------------------------------------------------------------
  logic               valid_q, valid_d;
  logic [width_p-1:0] data_q, data_d;

  always_comb begin
    valid_d = send;
    data_d  = data_q;
    if (send) begin
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

  // -------------------------------------------------------------------------
  // Stall watchdog (optional)
  // -------------------------------------------------------------------------
`ifdef BSG_LINK_CREDIT_STALL_WATCHDOG_EN
  localparam int wd_w_lp = $clog2(watchdog_cycles_p) + 1;
  localparam logic [wd_w_lp-1:0] wd_max_lp = wd_w_lp'(watchdog_cycles_p);

  logic [wd_w_lp-1:0] wd_cnt_q, wd_cnt_d;
  logic               stall_cond;

  assign stall_cond = link_enable_i & valid_i & (credit_q == '0);

  always_comb begin
    wd_cnt_d = '0;
    if (stall_cond) begin
      wd_cnt_d = (wd_cnt_q == wd_max_lp) ? wd_cnt_q : wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

  assign stall_o = (wd_cnt_q == wd_max_lp);
`else
  // The watchdog threshold has no effect in this build.
  logic unused_wd_cfg;
  assign unused_wd_cfg = (watchdog_cycles_p > 0);
  assign stall_o       = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_link_token_credit_tx.sv
// ---------------------------------------------------------------------------
// Testbench for bsg_link_token_credit_tx.
// Directed stimulus with hand-computed credit, ready, overflow and stall values.
// Every accepted word is pushed to a scoreboard together with the cycle in
// which it must appear. A separate monitor compares valid_o/data_o against it.
// ---------------------------------------------------------------------------
module tb_bsg_link_token_credit_tx;

  localparam int W = 32;
`ifdef BSG_LINK_CREDIT_STALL_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_i = 1'b0;
  logic          link_enable_i = 1'b1;
  logic          valid_i = 1'b0;
  logic [W-1:0]  data_i = '0;
  logic          ready_o;
  logic          valid_o;
  logic [W-1:0]  data_o;
  logic          token_i = 1'b0;
  logic [6:0]    credit_o;
  logic          overflow_o;
  logic          stall_o;

  bsg_link_token_credit_tx #(
    .width_p                         (W),
    .lg_fifo_depth_p                 (6),
    .lg_credit_to_token_decimation_p (3),
    .watchdog_cycles_p               (16)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .link_enable_i (link_enable_i),
    .valid_i       (valid_i),
    .data_i        (data_i),
    .ready_o       (ready_o),
    .valid_o       (valid_o),
    .data_o        (data_o),
    .token_i       (token_i),
    .credit_o      (credit_o),
    .overflow_o    (overflow_o),
    .stall_o       (stall_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [W-1:0] d;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid_o pulse must match the oldest expected word, and it
  // must appear in the expected cycle. An expected word whose cycle passes
  // without a pulse counts as a miss.
  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL out_unexpected: got valid_o=1 data %h expected no word (cycle %0d)", data_o, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("out_cycle", cyc, mon_e.cyc);
        chk("out_data", data_o, mon_e.d);
        $display("[TB] cycle %0d out word %h (expected %h)", cyc, data_o, mon_e.d);
      end
    end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      n_tests++;
      n_fail++;
      $display("FAIL out_missing: got valid_o=0 expected word %h in cycle %0d", sb_q[0].d, sb_q[0].cyc);
      void'(sb_q.pop_front());
    end
  end

  // One clock window. The task is entered just after a posedge. It drives the
  // inputs, checks the outputs at the negedge, and records the expected word
  // if the bench expects the word to be accepted.
  task automatic step(input string tag, input bit v, input logic [W-1:0] d, input bit e_rdy,
                      input int e_cr, input bit e_ovf, input bit e_stall);
    valid_i = v;
    data_i  = d;
    @(negedge clk);
    chk({tag, "_ready"},    ready_o,    32'(e_rdy));
    chk({tag, "_credit"},   credit_o,   32'(e_cr));
    chk({tag, "_overflow"}, overflow_o, 32'(e_ovf));
    chk({tag, "_stall"},    stall_o,    32'(e_stall));
    if (v && e_rdy) sb_q.push_back('{cyc + 1, d});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid_i       = 1'b0;
    token_i       = 1'b0;
    link_enable_i = 1'b1;
    #1 reset_i    = 1'b1;
    sb_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 reset_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // 1: drain all 64 credits back to back, then ready drops
    for (int i = 0; i < 64; i++) step("t1", 1'b1, 32'hA100_0000 + i, 1'b1, 64 - i, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++)  step("t1", 1'b1, 32'hA1FF_FFFF, 1'b0, 0, 1'b0, 1'b0);

    // 2: one token at credit 0 -> 8 credits after the synchronizer delay
    token_i = 1'b1;
    for (int k = 0; k < 3; k++) step("t2", 1'b1, 32'hA2FF_FFFF, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step("t2", 1'b1, 32'hA200_0000 + i, 1'b1, 8 - i, 1'b0, 1'b0);
    token_i = 1'b0;
    step("t2", 1'b1, 32'hA2FF_FFFE, 1'b0, 0, 1'b0, 1'b0);

    // 3: credit 5, send and token edge in the same cycle -> 12
    do_reset();
    for (int i = 0; i < 59; i++) step("t3", 1'b1, 32'hA300_0000 + i, 1'b1, 64 - i, 1'b0, 1'b0);
    token_i = 1'b1;
    step("t3", 1'b0, 32'h0, 1'b1, 5, 1'b0, 1'b0);
    step("t3", 1'b0, 32'h0, 1'b1, 5, 1'b0, 1'b0);
    step("t3", 1'b1, 32'hA3AA_0005, 1'b1, 5, 1'b0, 1'b0);
    step("t3", 1'b0, 32'h0, 1'b1, 12, 1'b0, 1'b0);
    token_i = 1'b0;

    // 4: credit 60 + token -> saturates at 64, sticky overflow
    do_reset();
    for (int i = 0; i < 4; i++) step("t4", 1'b1, 32'hA400_0000 + i, 1'b1, 64 - i, 1'b0, 1'b0);
    token_i = 1'b1;
    for (int k = 0; k < 3; k++) step("t4", 1'b0, 32'h0, 1'b1, 60, 1'b0, 1'b0);
    step("t4", 1'b0, 32'h0, 1'b1, 64, 1'b1, 1'b0);
    step("t4", 1'b1, 32'hA4BB_0001, 1'b1, 64, 1'b1, 1'b0);
    step("t4", 1'b0, 32'h0, 1'b1, 63, 1'b1, 1'b0);
    token_i = 1'b0;

    // 5a: asynchronous reset while a word is in flight
    step("t5", 1'b1, 32'hA5CC_0001, 1'b1, 63, 1'b1, 1'b0);
    #2 reset_i = 1'b1;
    sb_q.delete();
    #1;
    chk("t5_rst_valid",    valid_o,    32'd0);
    chk("t5_rst_credit",   credit_o,   32'd64);
    chk("t5_rst_overflow", overflow_o, 32'd0);
    valid_i = 1'b0;
    @(posedge clk);
    #1 reset_i = 1'b0;
    step("t5", 1'b0, 32'h0, 1'b1, 64, 1'b0, 1'b0);

    // 5b: link disabled for 10 cycles with token activity
    step("t5", 1'b1, 32'hA500_0000, 1'b1, 64, 1'b0, 1'b0);
    step("t5", 1'b1, 32'hA500_0001, 1'b1, 63, 1'b0, 1'b0);
    link_enable_i = 1'b0;
    for (int j = 0; j < 10; j++) begin
      token_i = ((j >= 1) && (j < 3)) || (j >= 5);
      step("t5", 1'b1, 32'hA5DD_0000 + j, 1'b0, (j == 0) ? 62 : 64, 1'b0, 1'b0);
    end
    link_enable_i = 1'b1;
    step("t5", 1'b1, 32'hA500_0002, 1'b1, 64, 1'b0, 1'b0);
    step("t5", 1'b0, 32'h0, 1'b1, 63, 1'b0, 1'b0);
    step("t5", 1'b0, 32'h0, 1'b1, 63, 1'b0, 1'b0);
    token_i = 1'b0;

    // 6: stall watchdog (16 cycles); stall_o stays 0 when compiled out
    do_reset();
    for (int i = 0; i < 64; i++) step("t6", 1'b1, 32'hA600_0000 + i, 1'b1, 64 - i, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      token_i = (k >= 16);
      step("t6", 1'b1, 32'hA6EE_0000 + k, (k == 19), (k == 19) ? 8 : 0, 1'b0, WD_EN && (k >= 16));
    end
    step("t6", 1'b1, 32'hA6EE_0100, 1'b1, 7, 1'b0, 1'b0);
    step("t6", 1'b0, 32'h0, 1'b1, 6, 1'b0, 1'b0);
    token_i = 1'b0;

    @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
